// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM command path: the 2-bit command codes carried in
// rx_data[9:8], default RAM geometry, and a saturating counter increment.
// The SPI slave imports the same package for its own command checks.
package spi_ram_pkg;

  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int DATA_W        = 8;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_ram_cmd_ctrl_if.sv
// Bundle between the SPI slave and the command controller.
//   din      : {cmd[1:0], payload[ADDR_SIZE-1:0]} from the slave
//   rx_valid : din qualifier (level, may stay high for several cycles)
//   err_clr  : synchronous clear of seq_err
//   dout     : read byte for MISO, tx_valid qualifies it
//   seq_err  : sticky data-without-address error
//   wr_cnt / rd_cnt : saturating transaction counters
// master = SPI slave side, slave = command controller side.
interface spi_ram_cmd_ctrl_if
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) ();

  logic [ADDR_SIZE+1:0] din;
  logic                 rx_valid;
  logic                 err_clr;
  logic [DATA_W-1:0]    dout;
  logic                 tx_valid;
  logic                 seq_err;
  logic [CNT_W-1:0]     wr_cnt;
  logic [CNT_W-1:0]     rd_cnt;

  modport master (
    output din, rx_valid, err_clr,
    input  dout, tx_valid, seq_err, wr_cnt, rd_cnt
  );

  modport slave (
    input  din, rx_valid, err_clr,
    output dout, tx_valid, seq_err, wr_cnt, rd_cnt
  );

endinterface

// File: rtl/sp_ram_array.sv
// Single-port RAM, MEM_DEPTH x DATA_W, synchronous write and synchronous read.
//   clk   : clock
//   en    : access enable; rdata only changes on an enabled read
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, held between reads
module sp_ram_array
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // NOTE: the array and its read register have no reset, so the array maps onto block
  // RAM and its contents survive rst_n; the controller masks rdata until the first read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_cmd_ctrl.sv
// Command decoder + RAM behind the SPI slave.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spi_ram_cmd_ctrl_if.slave (din/rx_valid/err_clr in; dout/tx_valid/
//                seq_err/wr_cnt/rd_cnt out)
// One command is accepted per rx_valid rising edge. WR_ADDR/RD_ADDR latch an address
// and mark it valid; WR_DATA/RD_DATA access the RAM only when the matching address is
// valid, otherwise they raise the sticky seq_err. Read data appears on dout with
// tx_valid on the accepting edge and is held until the next accepted command.
module spi_ram_cmd_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,  // must equal 2**ADDR_SIZE
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,  // equals payload width
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_ram_cmd_ctrl_if.slave   bus
);

  logic                 rx_valid_q;
  logic                 accept;
  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] payload;

  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wr_vld, rd_vld;
  logic                 rd_seen;  // rdata holds a real read; masks the unreset RAM register
  logic                 do_wr, do_rd, seq_bad;
  logic [DATA_W-1:0]    ram_rdata;

  assign accept  = bus.rx_valid & ~rx_valid_q;
  assign cmd     = cmd_e'(bus.din[ADDR_SIZE+1 -: 2]);
  assign payload = bus.din[ADDR_SIZE-1:0];

  assign do_wr   = accept && (cmd == CMD_WR_DATA) && wr_vld;
  assign do_rd   = accept && (cmd == CMD_RD_DATA) && rd_vld;
  assign seq_bad = accept && (((cmd == CMD_WR_DATA) && !wr_vld) ||
                              ((cmd == CMD_RD_DATA) && !rd_vld));

  // One access per accept, so a single port shared between the two address registers suffices.
  sp_ram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .en    (do_wr | do_rd),
    .we    (do_wr),
    .addr  (do_wr ? wr_addr : rd_addr),
    .wdata (payload[DATA_W-1:0]),
    .rdata (ram_rdata)
  );

  // rdata only reloads on a valid RD_DATA, which gives the required hold behaviour for free.
  assign bus.dout = rd_seen ? ram_rdata : '0;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q   <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      wr_vld       <= 1'b0;
      rd_vld       <= 1'b0;
      rd_seen      <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.seq_err  <= 1'b0;
      bus.wr_cnt   <= '0;
      bus.rd_cnt   <= '0;
    end else begin
      rx_valid_q <= bus.rx_valid;

      if (accept) begin
        bus.tx_valid <= do_rd;
        unique case (cmd)
          CMD_WR_ADDR: begin
            wr_addr <= payload;
            wr_vld  <= 1'b1;
          end
          CMD_WR_DATA: begin
            if (wr_vld && AUTO_INC) wr_addr <= wr_addr + 1'b1;
          end
          CMD_RD_ADDR: begin
            rd_addr <= payload;
            rd_vld  <= 1'b1;
          end
          CMD_RD_DATA: begin
            if (rd_vld) begin
              if (AUTO_INC) rd_addr <= rd_addr + 1'b1;
              else          rd_vld  <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (do_rd) rd_seen <= 1'b1;

      // A new error beats a simultaneous clear.
      if (seq_bad)          bus.seq_err <= 1'b1;
      else if (bus.err_clr) bus.seq_err <= 1'b0;

      if (do_wr) bus.wr_cnt <= sat_inc(bus.wr_cnt);
      if (do_rd) bus.rd_cnt <= sat_inc(bus.rd_cnt);
    end
  end

endmodule

// File: tb/tb_spi_ram_cmd_ctrl.sv
// Bench for spi_ram_cmd_ctrl. Two instances (AUTO_INC=0 and AUTO_INC=1) receive the
// same stimulus; each is compared against its own reference model.
module tb_spi_ram_cmd_ctrl;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] drv_din = '0;
  logic       drv_rv  = 1'b0;
  logic       drv_clr = 1'b0;

  spi_ram_cmd_ctrl_if #(.ADDR_SIZE(8)) if0 ();
  spi_ram_cmd_ctrl_if #(.ADDR_SIZE(8)) if1 ();

  assign if0.din = drv_din;  assign if0.rx_valid = drv_rv;  assign if0.err_clr = drv_clr;
  assign if1.din = drv_din;  assign if1.rx_valid = drv_rv;  assign if1.err_clr = drv_clr;

  spi_ram_cmd_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  spi_ram_cmd_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [7:0]  obs_dout [2];
  logic        obs_tx   [2];
  logic        obs_err  [2];
  logic [15:0] obs_wc   [2];
  logic [15:0] obs_rc   [2];
  assign obs_dout[0] = if0.dout;    assign obs_dout[1] = if1.dout;
  assign obs_tx[0]   = if0.tx_valid; assign obs_tx[1]  = if1.tx_valid;
  assign obs_err[0]  = if0.seq_err; assign obs_err[1]  = if1.seq_err;
  assign obs_wc[0]   = if0.wr_cnt;  assign obs_wc[1]   = if1.wr_cnt;
  assign obs_rc[0]   = if0.rd_cnt;  assign obs_rc[1]   = if1.rd_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [7:0] m_mem   [2][256];
  bit         m_known [2][256];
  logic [7:0] m_wa [2], m_ra [2], m_dout [2];
  bit         m_wv [2], m_rv [2], m_dknown [2], m_tx [2], m_err [2], m_prev [2];
  int         m_wc [2], m_rc [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wa[k] = 0; m_ra[k] = 0; m_wv[k] = 0; m_rv[k] = 0;
      m_dout[k] = 0; m_dknown[k] = 1; m_tx[k] = 0; m_err[k] = 0;
      m_wc[k] = 0; m_rc[k] = 0; m_prev[k] = 0;
    end
  endfunction

  // Applies one clock edge of inputs to model k (k==1 is the auto-increment instance).
  function automatic void model_step(int k);
    bit acc = drv_rv && !m_prev[k];
    bit err_set = 0;
    logic [7:0] p = drv_din[7:0];
    m_prev[k] = drv_rv;
    if (acc) begin
      m_tx[k] = 0;
      case (drv_din[9:8])
        2'd0: begin m_wa[k] = p; m_wv[k] = 1; end
        2'd1: if (m_wv[k]) begin
                m_mem[k][m_wa[k]] = p; m_known[k][m_wa[k]] = 1;
                if (m_wc[k] < 65535) m_wc[k]++;
                if (k == 1) m_wa[k] = m_wa[k] + 8'd1;
              end else err_set = 1;
        2'd2: begin m_ra[k] = p; m_rv[k] = 1; end
        default: if (m_rv[k]) begin
                m_dout[k] = m_mem[k][m_ra[k]]; m_dknown[k] = m_known[k][m_ra[k]];
                m_tx[k] = 1;
                if (m_rc[k] < 65535) m_rc[k]++;
                if (k == 1) m_ra[k] = m_ra[k] + 8'd1; else m_rv[k] = 0;
              end else err_set = 1;
      endcase
    end
    if (err_set) m_err[k] = 1;
    else if (drv_clr) m_err[k] = 0;
  endfunction

  // ---------------- stimulus helpers (entered and left at a falling edge) ----------------
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] p, input int hold = 1, input bit clr = 0);
    drv_din = {cmd, p}; drv_rv = 1'b1; drv_clr = clr;
    repeat (hold) tick();
    drv_rv = 1'b0; drv_clr = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    drv_rv = 1'b0; drv_clr = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_dout[k] !== 8'h00) $display("FAIL reset_dout[%0d]: got %h want 00", k, obs_dout[k]); else n_pass++;
      n_checks++; if (obs_tx[k] !== 1'b0)    $display("FAIL reset_tx[%0d]: got %b want 0", k, obs_tx[k]); else n_pass++;
      n_checks++; if (obs_err[k] !== 1'b0)   $display("FAIL reset_err[%0d]: got %b want 0", k, obs_err[k]); else n_pass++;
      n_checks++; if (obs_wc[k] !== 16'h0 || obs_rc[k] !== 16'h0)
        $display("FAIL reset_cnt[%0d]: got %h/%h want 0/0", k, obs_wc[k], obs_rc[k]); else n_pass++;
    end
  endtask

  task automatic test_basic();
    send(CMD_WR_ADDR, 8'h12); send(CMD_WR_DATA, 8'hA5); send(CMD_RD_ADDR, 8'h12);
    drv_din = {CMD_RD_DATA, 8'h00}; drv_rv = 1'b1;
    tick();  // one cycle after the accepting edge
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_tx[k] !== 1'b1 || obs_dout[k] !== 8'hA5)
        $display("FAIL basic_read[%0d]: got tx=%b dout=%h want tx=1 dout=a5", k, obs_tx[k], obs_dout[k]); else n_pass++;
    end
    drv_rv = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_tx[k] !== 1'b1 || obs_dout[k] !== 8'hA5)
        $display("FAIL basic_hold[%0d]: got tx=%b dout=%h want tx=1 dout=a5", k, obs_tx[k], obs_dout[k]); else n_pass++;
      n_checks++; if (obs_wc[k] !== 16'd1 || obs_rc[k] !== 16'd1)
        $display("FAIL basic_cnt[%0d]: got %0d/%0d want 1/1", k, obs_wc[k], obs_rc[k]); else n_pass++;
    end
    send(CMD_WR_ADDR, 8'h30);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_tx[k] !== 1'b0) $display("FAIL basic_txclr[%0d]: got %b want 0", k, obs_tx[k]); else n_pass++;
    end
  endtask

  task automatic test_seq_err();
    do_reset();
    send(CMD_WR_ADDR, 8'h00); send(CMD_WR_DATA, 8'h5A);
    do_reset();
    send(CMD_RD_DATA, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_err[k] !== 1'b1 || obs_tx[k] !== 1'b0)
        $display("FAIL seq_rd[%0d]: got err=%b tx=%b want err=1 tx=0", k, obs_err[k], obs_tx[k]); else n_pass++;
    end
    send(CMD_WR_DATA, 8'h33);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_wc[k] !== 16'd0 || obs_rc[k] !== 16'd0 || obs_err[k] !== 1'b1)
        $display("FAIL seq_cnt[%0d]: got wc=%0d rc=%0d err=%b want 0 0 1", k, obs_wc[k], obs_rc[k], obs_err[k]); else n_pass++;
    end
    drv_clr = 1'b1; tick(); drv_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_err[k] !== 1'b0) $display("FAIL seq_clr[%0d]: got %b want 0", k, obs_err[k]); else n_pass++;
    end
    send(CMD_RD_ADDR, 8'h00); send(CMD_RD_DATA, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_dout[k] !== 8'h5A) $display("FAIL seq_mem0[%0d]: got %h want 5a", k, obs_dout[k]); else n_pass++;
    end
  endtask

  task automatic test_rx_hold();
    int wc_exp [2];
    send(CMD_WR_ADDR, 8'h40);
    for (int k = 0; k < 2; k++) wc_exp[k] = m_wc[k] + 1;
    send(CMD_WR_DATA, 8'h9C, 5);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_wc[k] !== wc_exp[k][15:0])
        $display("FAIL hold_wcnt[%0d]: got %0d want %0d", k, obs_wc[k], wc_exp[k]); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send(CMD_WR_ADDR, 8'hFF); send(CMD_WR_DATA, 8'h01); send(CMD_WR_DATA, 8'h02);
    send(CMD_RD_ADDR, 8'hFF); send(CMD_RD_DATA, 8'h00);
    n_checks++; if (obs_dout[1] !== 8'h01 || obs_tx[1] !== 1'b1)
      $display("FAIL wrap_rd0: got dout=%h tx=%b want 01 1", obs_dout[1], obs_tx[1]); else n_pass++;
    n_checks++; if (obs_dout[0] !== m_dout[0]) $display("FAIL wrap_rd0_noinc: got %h want %h", obs_dout[0], m_dout[0]); else n_pass++;
    send(CMD_RD_DATA, 8'h00);
    n_checks++; if (obs_dout[1] !== 8'h02 || obs_err[1] !== 1'b0)
      $display("FAIL wrap_rd1: got dout=%h err=%b want 02 0", obs_dout[1], obs_err[1]); else n_pass++;
    n_checks++; if (obs_err[0] !== m_err[0] || obs_tx[0] !== m_tx[0])
      $display("FAIL wrap_rd1_noinc: got err=%b tx=%b want %b %b", obs_err[0], obs_tx[0], m_err[0], m_tx[0]); else n_pass++;
  endtask

  task automatic test_rd_no_inc();
    do_reset();
    send(CMD_WR_ADDR, 8'h05); send(CMD_WR_DATA, 8'hC3);
    send(CMD_RD_ADDR, 8'h05); send(CMD_RD_DATA, 8'h00);
    n_checks++; if (obs_dout[0] !== 8'hC3 || obs_tx[0] !== 1'b1)
      $display("FAIL noinc_rd0: got dout=%h tx=%b want c3 1", obs_dout[0], obs_tx[0]); else n_pass++;
    send(CMD_RD_DATA, 8'h00);
    n_checks++; if (obs_err[0] !== 1'b1 || obs_tx[0] !== 1'b0 || obs_dout[0] !== 8'hC3)
      $display("FAIL noinc_rd1: got err=%b tx=%b dout=%h want 1 0 c3", obs_err[0], obs_tx[0], obs_dout[0]); else n_pass++;
    n_checks++; if (obs_err[1] !== 1'b0 || obs_tx[1] !== 1'b1)
      $display("FAIL inc_rd1: got err=%b tx=%b want 0 1", obs_err[1], obs_tx[1]); else n_pass++;
  endtask

  task automatic test_clr_collision();
    do_reset();
    send(CMD_WR_DATA, 8'h11, 1, 1'b1);  // error and clear on the same edge
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_err[k] !== 1'b1) $display("FAIL clr_collide[%0d]: got %b want 1", k, obs_err[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(CMD_WR_ADDR, 8'h21); send(CMD_WR_DATA, 8'h6E);
    send(CMD_RD_ADDR, 8'h21); send(CMD_RD_DATA, 8'h00);
    drv_din = {CMD_WR_DATA, 8'h99}; drv_rv = 1'b1;  // in flight, dropped by reset
    #2;
    rst_n = 1'b0; drv_rv = 1'b0; model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_tx[k] !== 1'b0 || obs_err[k] !== 1'b0 || obs_wc[k] !== 16'd0 || obs_rc[k] !== 16'd0 || obs_dout[k] !== 8'h00)
        $display("FAIL rst_async[%0d]: got tx=%b err=%b wc=%0d rc=%0d dout=%h want all 0",
                 k, obs_tx[k], obs_err[k], obs_wc[k], obs_rc[k], obs_dout[k]); else n_pass++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(CMD_RD_ADDR, 8'h21); send(CMD_RD_DATA, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (obs_dout[k] !== 8'h6E || obs_tx[k] !== 1'b1)
        $display("FAIL rst_ramkeep[%0d]: got dout=%h tx=%b want 6e 1", k, obs_dout[k], obs_tx[k]); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      logic [1:0] c = 2'($urandom_range(0, 3));
      logic [7:0] p = (c[0] == 1'b0) ? (($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 15)))
                                     : 8'($urandom_range(0, 255));
      send(c, p, $urandom_range(1, 3), ($urandom_range(0, 7) == 0));
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (obs_tx[k] !== m_tx[k]) $display("FAIL rand_tx[%0d] i=%0d: got %b want %b", k, i, obs_tx[k], m_tx[k]); else n_pass++;
        n_checks++; if (obs_err[k] !== m_err[k]) $display("FAIL rand_err[%0d] i=%0d: got %b want %b", k, i, obs_err[k], m_err[k]); else n_pass++;
        n_checks++; if (obs_wc[k] !== m_wc[k][15:0] || obs_rc[k] !== m_rc[k][15:0])
          $display("FAIL rand_cnt[%0d] i=%0d: got %0d/%0d want %0d/%0d", k, i, obs_wc[k], obs_rc[k], m_wc[k], m_rc[k]); else n_pass++;
        if (m_dknown[k]) begin
          n_checks++; if (obs_dout[k] !== m_dout[k]) $display("FAIL rand_dout[%0d] i=%0d: got %h want %h", k, i, obs_dout[k], m_dout[k]); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    test_reset();
    test_basic();
    test_seq_err();
    test_rx_hold();
    test_wrap();
    test_rd_no_inc();
    test_clr_collision();
    test_reset_mid();
    do_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
